// File: rtl/cd_frame_ring.sv
// cd_frame_ring: multi-slot frame buffer ring between a frame producer and a
// consumer. The writer always owns one slot; committed slots queue up for the
// reader, with per-frame flags and length, occupancy, full and drop tracking.
module cd_frame_ring #(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned N_WIDTH = 2,
  parameter int unsigned F_WIDTH = 8,
  parameter int unsigned C_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic               wr_en,
  input  logic               wr_commit,
  input  logic [F_WIDTH-1:0] wr_flags,
  input  logic [A_WIDTH:0]   wr_len,
  input  logic               wr_abort,
  output logic               commit_fail,
  output logic [C_WIDTH-1:0] drop_cnt,
  output logic               full,
  input  logic [A_WIDTH-1:0] rd_addr,
  input  logic               rd_en,
  output logic [D_WIDTH-1:0] rd_data,
  output logic [F_WIDTH-1:0] rd_flags,
  output logic [A_WIDTH:0]   rd_len,
  input  logic               rd_done,
  input  logic               flush,
  output logic               unread,
  output logic [N_WIDTH-1:0] count
);

  localparam int unsigned SLOTS   = 1 << N_WIDTH;
  localparam int unsigned DEPTH   = 1 << A_WIDTH;
  localparam int unsigned L_WIDTH = A_WIDTH + 1;

  logic [N_WIDTH-1:0] wr_sel, wr_sel_n;
  logic [N_WIDTH-1:0] rd_sel, rd_sel_n;
  logic [SLOTS-1:0]   dirty, dirty_n;
  logic [N_WIDTH-1:0] count_n;
  logic               commit_fail_n;
  logic [C_WIDTH-1:0] drop_cnt_n;

  logic [F_WIDTH-1:0] flags_r [SLOTS];
  logic [L_WIDTH-1:0] len_r   [SLOTS];

  logic [D_WIDTH-1:0] slot_q  [SLOTS];
  logic [N_WIDTH-1:0] rd_slot;

  logic [N_WIDTH-1:0] wr_sel_inc;
  logic               commit_req;
  logic               commit_blocked;
  logic               commit_ok;
  logic               release_ok;

  // Abort masks a simultaneous commit; fullness is judged on pre-edge dirty bits
  assign wr_sel_inc     = wr_sel + N_WIDTH'(1);
  assign commit_req     = wr_commit & ~wr_abort;
  assign commit_blocked = commit_req & dirty[wr_sel_inc];
  assign commit_ok      = commit_req & ~dirty[wr_sel_inc];
  assign release_ok     = rd_done & dirty[rd_sel];

  // Per-slot simple dual-port RAM with a registered, enabled read port
  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    logic [D_WIDTH-1:0] mem [DEPTH];
    logic               we;
    logic               re;
    logic [D_WIDTH-1:0] q;

    assign we = wr_en & (wr_sel == N_WIDTH'(s));
    assign re = rd_en & (rd_sel == N_WIDTH'(s));

    // RAM write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
    end

    // RAM read port, holds its word while the read enable is low
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  q <= '0;
      else if (re)   q <= mem[rd_addr];
    end

    assign slot_q[s] = q;
  end

  // Only the slot captured on the last read drives rd_data
  assign rd_data = slot_q[rd_slot];

  // Ring bookkeeping: flush dominates, otherwise commit and release combine
  always_comb begin
    wr_sel_n      = wr_sel;
    rd_sel_n      = rd_sel;
    dirty_n       = dirty;
    count_n       = count;
    commit_fail_n = 1'b0;
    drop_cnt_n    = drop_cnt;

    if (flush) begin
      wr_sel_n = '0;
      rd_sel_n = '0;
      dirty_n  = '0;
      count_n  = '0;
    end else begin
      if (commit_blocked) begin
        commit_fail_n = 1'b1;
        if (drop_cnt != {C_WIDTH{1'b1}}) drop_cnt_n = drop_cnt + C_WIDTH'(1);
      end
      if (commit_ok) begin
        dirty_n[wr_sel] = 1'b1;
        wr_sel_n        = wr_sel_inc;
      end
      if (release_ok) begin
        dirty_n[rd_sel] = 1'b0;
        rd_sel_n        = rd_sel + N_WIDTH'(1);
      end
      case ({commit_ok, release_ok})
        2'b10:   count_n = count + N_WIDTH'(1);
        2'b01:   count_n = count - N_WIDTH'(1);
        default: count_n = count;
      endcase
    end
  end

  // Ring state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_sel      <= '0;
      rd_sel      <= '0;
      dirty       <= '0;
      count       <= '0;
      commit_fail <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      wr_sel      <= wr_sel_n;
      rd_sel      <= rd_sel_n;
      dirty       <= dirty_n;
      count       <= count_n;
      commit_fail <= commit_fail_n;
      drop_cnt    <= drop_cnt_n;
    end
  end

  // Per-frame descriptor capture on a successful commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        flags_r[i] <= '0;
        len_r[i]   <= '0;
      end
    end else if (!flush && commit_ok) begin
      flags_r[wr_sel] <= wr_flags;
      len_r[wr_sel]   <= wr_len;
    end
  end

  // Read-side descriptor; a clean slot reports zero flags and length
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_slot  <= '0;
      rd_flags <= '0;
      rd_len   <= '0;
    end else if (rd_en) begin
      rd_slot  <= rd_sel;
      rd_flags <= dirty[rd_sel] ? flags_r[rd_sel] : '0;
      rd_len   <= dirty[rd_sel] ? len_r[rd_sel]   : '0;
    end
  end

  assign unread = |dirty;
  assign full   = (count == N_WIDTH'(SLOTS - 1));

endmodule

// File: tb/tb_cd_frame_ring.sv
// Self-checking bench for cd_frame_ring with a read scoreboard fed by a
// behavioural ring model.
module tb_cd_frame_ring;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] wr_data;
  logic [7:0] wr_addr;
  logic       wr_en;
  logic       wr_commit;
  logic [7:0] wr_flags;
  logic [8:0] wr_len;
  logic       wr_abort;
  logic       commit_fail;
  logic [1:0] drop_cnt;
  logic       full;
  logic [7:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [7:0] rd_flags;
  logic [8:0] rd_len;
  logic       rd_done;
  logic       flush;
  logic       unread;
  logic [1:0] count;

  int checks = 0;
  int errors = 0;

  cd_frame_ring #(
    .D_WIDTH(8), .A_WIDTH(8), .N_WIDTH(2), .F_WIDTH(8), .C_WIDTH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_commit(wr_commit), .wr_flags(wr_flags), .wr_len(wr_len),
    .wr_abort(wr_abort), .commit_fail(commit_fail), .drop_cnt(drop_cnt),
    .full(full), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_flags(rd_flags), .rd_len(rd_len), .rd_done(rd_done),
    .flush(flush), .unread(unread), .count(count)
  );

  always #5 clk = ~clk;

  // Behavioural model
  logic [7:0] m_mem [4][256];
  logic [7:0] m_flags [4];
  logic [8:0] m_len [4];
  logic [3:0] m_dirty;
  logic [1:0] m_wr, m_rd;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] f;
    logic [8:0] l;
  } rd_exp_t;
  rd_exp_t sb[$];

  task automatic idle();
    wr_data = 8'h00; wr_addr = 8'h00; wr_en = 1'b0; wr_commit = 1'b0;
    wr_flags = 8'h00; wr_len = 9'h000; wr_abort = 1'b0;
    rd_addr = 8'h00; rd_en = 1'b0; rd_done = 1'b0; flush = 1'b0;
  endtask

  task automatic model_reset();
    m_wr = 2'd0; m_rd = 2'd0; m_dirty = 4'h0;
    sb.delete();
  endtask

  // Apply the current inputs to the model, then advance one clock
  task automatic cyc();
    rd_exp_t    e;
    logic [1:0] nx;
    logic       creq, cok, rok;
    if (rd_en) begin
      e.d = m_mem[m_rd][rd_addr];
      e.f = m_dirty[m_rd] ? m_flags[m_rd] : 8'h00;
      e.l = m_dirty[m_rd] ? m_len[m_rd] : 9'h000;
      sb.push_back(e);
    end
    if (wr_en) m_mem[m_wr][wr_addr] = wr_data;
    nx   = m_wr + 2'd1;
    creq = wr_commit && !wr_abort;
    cok  = creq && !m_dirty[nx];
    rok  = rd_done && m_dirty[m_rd];
    if (flush) begin
      m_wr = 2'd0; m_rd = 2'd0; m_dirty = 4'h0;
    end else begin
      if (cok) begin
        m_dirty[m_wr] = 1'b1; m_flags[m_wr] = wr_flags; m_len[m_wr] = wr_len;
        m_wr = nx;
      end
      if (rok) begin
        m_dirty[m_rd] = 1'b0;
        m_rd = m_rd + 2'd1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    idle(); wr_en = 1'b1; wr_addr = a; wr_data = d; cyc(); idle();
  endtask

  task automatic do_commit(input logic [7:0] f, input logic [8:0] l);
    idle(); wr_commit = 1'b1; wr_flags = f; wr_len = l; cyc(); idle();
  endtask

  task automatic do_read(input logic [7:0] a);
    idle(); rd_en = 1'b1; rd_addr = a; cyc(); idle();
  endtask

  task automatic do_release();
    idle(); rd_done = 1'b1; cyc(); idle();
  endtask

  // Read monitor: pops the scoreboard one cycle after each read strobe
  always begin
    logic    pend;
    rd_exp_t e;
    @(posedge clk);
    pend = rd_en && reset_n;
    #1;
    if (pend) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow got read data %h with no expected entry", rd_data);
      end else begin
        e = sb.pop_front();
        if ({rd_data, rd_flags, rd_len} !== {e.d, e.f, e.l}) begin
          errors++;
          $display("FAIL sb_read got data=%h flags=%h len=%0d exp data=%h flags=%h len=%0d",
                   rd_data, rd_flags, rd_len, e.d, e.f, e.l);
        end
      end
    end
  end

  task automatic test_reset();
    idle(); reset_n = 1'b0; model_reset();
    #12;
    checks++;
    if ({count, unread, full, commit_fail, drop_cnt} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state got count=%0d unread=%b full=%b fail=%b drop=%0d exp all 0",
               count, unread, full, commit_fail, drop_cnt);
    end
    checks++;
    if ({rd_data, rd_flags, rd_len} !== 25'b0) begin
      errors++;
      $display("FAIL reset_read got data=%h flags=%h len=%0d exp 0", rd_data, rd_flags, rd_len);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) do_write(8'(i), 8'(8'h11 + i));
    do_commit(8'hA5, 9'd4);
    checks++;
    if (unread !== 1'b1 || count !== 2'd1 || full !== 1'b0) begin
      errors++;
      $display("FAIL basic_commit got unread=%b count=%0d full=%b exp 1 1 0", unread, count, full);
    end
    do_read(8'd2);
    checks++;
    if (rd_data !== 8'h13 || rd_flags !== 8'hA5 || rd_len !== 9'd4) begin
      errors++;
      $display("FAIL basic_read got %h/%h/%0d exp 13/a5/4", rd_data, rd_flags, rd_len);
    end
    do_release();
    checks++;
    if (count !== 2'd0 || unread !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got count=%0d unread=%b exp 0 0", count, unread);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 3; i++) begin
      do_write(8'd0, 8'(8'hA1 + i));
      do_commit(8'(8'h10 + i), 9'(i + 1));
    end
    checks++;
    if (count !== 2'd3 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_fill got count=%0d full=%b exp 3 1", count, full);
    end
    do_commit(8'hEE, 9'd7);
    checks++;
    if (commit_fail !== 1'b1 || drop_cnt !== 2'd1 || count !== 2'd3) begin
      errors++;
      $display("FAIL full_refuse got fail=%b drop=%0d count=%0d exp 1 1 3",
               commit_fail, drop_cnt, count);
    end
    cyc();
    checks++;
    if (commit_fail !== 1'b0) begin
      errors++;
      $display("FAIL full_pulse got fail=%b exp 0", commit_fail);
    end
    do_read(8'd0);
  endtask

  task automatic test_full_release();
    idle(); wr_commit = 1'b1; wr_flags = 8'hEF; wr_len = 9'd3; rd_done = 1'b1;
    cyc(); idle();
    checks++;
    if (commit_fail !== 1'b1 || count !== 2'd2 || drop_cnt !== 2'd2 || full !== 1'b0) begin
      errors++;
      $display("FAIL fullrel_edge got fail=%b count=%0d drop=%0d full=%b exp 1 2 2 0",
               commit_fail, count, drop_cnt, full);
    end
    do_read(8'd0);
    checks++;
    if (rd_flags !== 8'h11) begin
      errors++;
      $display("FAIL fullrel_rdsel got flags=%h exp 11", rd_flags);
    end
    do_release();
    do_release();
    checks++;
    if (count !== 2'd0 || unread !== 1'b0) begin
      errors++;
      $display("FAIL fullrel_drain got count=%0d unread=%b exp 0 0", count, unread);
    end
  endtask

  task automatic test_back_to_back();
    do_commit(8'h40, 9'd256);
    do_read(8'd0);
    checks++;
    if (rd_len !== 9'd256 || rd_data !== 8'h11) begin
      errors++;
      $display("FAIL b2b_maxlen got len=%0d data=%h exp 256 11", rd_len, rd_data);
    end
    idle(); wr_commit = 1'b1; wr_flags = 8'h41; wr_len = 9'd0; rd_done = 1'b1;
    cyc(); idle();
    checks++;
    if (count !== 2'd1 || commit_fail !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count got count=%0d fail=%b exp 1 0", count, commit_fail);
    end
    do_read(8'd0);
    checks++;
    if (rd_flags !== 8'h41 || rd_len !== 9'd0) begin
      errors++;
      $display("FAIL b2b_rdsel got flags=%h len=%0d exp 41 0", rd_flags, rd_len);
    end
    do_release();
    do_release();
    checks++;
    if (count !== 2'd0) begin
      errors++;
      $display("FAIL b2b_clean_release got count=%0d exp 0", count);
    end
    do_read(8'd0);
  endtask

  task automatic test_reset_midframe();
    do_commit(8'h3C, 9'd1);
    do_read(8'd0);
    idle(); wr_en = 1'b1; wr_addr = 8'd3; wr_data = 8'h55;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({count, unread, full, commit_fail, drop_cnt, rd_data, rd_flags, rd_len} !== 32'b0) begin
      errors++;
      $display("FAIL midreset_async got count=%0d unread=%b full=%b fail=%b drop=%0d rd=%h/%h/%0d exp 0",
               count, unread, full, commit_fail, drop_cnt, rd_data, rd_flags, rd_len);
    end
    idle();
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_write(8'd5, 8'h77);
    do_commit(8'h99, 9'd6);
    checks++;
    if (count !== 2'd1) begin
      errors++;
      $display("FAIL midreset_commit got count=%0d exp 1", count);
    end
    do_read(8'd5);
    checks++;
    if (rd_data !== 8'h77 || rd_flags !== 8'h99 || rd_len !== 9'd6) begin
      errors++;
      $display("FAIL midreset_slot0 got %h/%h/%0d exp 77/99/6", rd_data, rd_flags, rd_len);
    end
  endtask

  task automatic test_drop_sat();
    logic [1:0] exp_drop [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_commit(8'h51, 9'd1);
    do_commit(8'h52, 9'd2);
    idle(); wr_commit = 1'b1; wr_abort = 1'b1; cyc(); idle();
    checks++;
    if (commit_fail !== 1'b0 || drop_cnt !== 2'd0 || count !== 2'd3) begin
      errors++;
      $display("FAIL abort_wins got fail=%b drop=%0d count=%0d exp 0 0 3",
               commit_fail, drop_cnt, count);
    end
    idle(); wr_commit = 1'b1; wr_flags = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (drop_cnt !== exp_drop[i] || commit_fail !== 1'b1) begin
        errors++;
        $display("FAIL drop_sat_%0d got drop=%0d fail=%b exp %0d 1",
                 i, drop_cnt, commit_fail, exp_drop[i]);
      end
    end
    idle(); flush = 1'b1; wr_commit = 1'b1; rd_done = 1'b1; cyc(); idle();
    checks++;
    if (count !== 2'd0 || unread !== 1'b0 || full !== 1'b0 || drop_cnt !== 2'd3 || commit_fail !== 1'b0) begin
      errors++;
      $display("FAIL flush_state got count=%0d unread=%b full=%b drop=%0d fail=%b exp 0 0 0 3 0",
               count, unread, full, drop_cnt, commit_fail);
    end
    do_commit(8'h42, 9'd2);
    do_read(8'd5);
    checks++;
    if (rd_flags !== 8'h42) begin
      errors++;
      $display("FAIL flush_ptr got flags=%h exp 42", rd_flags);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_full_release();
    test_back_to_back();
    test_reset_midframe();
    test_drop_sat();
    cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cd_frame_ring.md
Name: cd_frame_ring

Overview:
Multi-slot frame buffer ring between a frame producer (e.g. the rx deserialiser) and a consumer (e.g. the CPU register interface). It holds 2**N_WIDTH slots of 2**A_WIDTH words each. Each committed slot stores a per-frame flags word and a length. The block also maintains an occupancy count, a full indication and a saturating drop counter, and supports write abort and whole-ring flush.

Parameters:
D_WIDTH, 8, data word width in bits
A_WIDTH, 8, word address width per slot; slot depth = 2**A_WIDTH
N_WIDTH, 2, slot index width; slot count = 2**N_WIDTH (N_WIDTH >= 1)
F_WIDTH, 8, per-frame flags width
C_WIDTH, 8, drop counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active-low
wr_data  in  D_WIDTH  write word
wr_addr  in  A_WIDTH  word address within current write slot
wr_en  in  1  write strobe; stores wr_data at wr_addr in the write slot
wr_commit  in  1  close the write slot as a frame, using wr_flags and wr_len
wr_flags  in  F_WIDTH  flags stored on commit
wr_len  in  A_WIDTH+1  frame length in words, stored on commit (0..2**A_WIDTH)
wr_abort  in  1  discard the current write slot contents; write slot unchanged
commit_fail  out  1  one-cycle pulse: a commit was refused because the ring was full
drop_cnt  out  C_WIDTH  saturating count of refused commits
full  out  1  committed slot count == 2**N_WIDTH-1
rd_addr  in  A_WIDTH  word address within the read slot
rd_en  in  1  read strobe
rd_data  out  D_WIDTH  read word, registered
rd_flags  out  F_WIDTH  flags of the read slot, registered
rd_len  out  A_WIDTH+1  length of the read slot, registered
rd_done  in  1  release the read slot and advance
flush  in  1  drop all frames and reset the pointers
unread  out  1  at least one committed frame is pending
count  out  N_WIDTH  number of committed, unread frames

Behaviour:
- Reset (async): wr_sel=0, rd_sel=0, dirty=0, count=0, drop_cnt=0, commit_fail=0, rd_data=0, rd_flags=0, rd_len=0.
- Storage: one simple dual-port RAM per slot, with a synchronous read enable.
  - RAM write enable for slot i is wr_en & (wr_sel==i).
  - RAM read enable for slot i is rd_en & (rd_sel==i).
- Read latency: 1 cycle. rd_data/rd_flags/rd_len update on the clk edge after rd_en and hold while rd_en is low.
- The read side only reflects slot rd_sel. Reading a non-dirty slot returns the RAM contents with rd_flags=0 and rd_len=0.
- Commit, when wr_commit=1:
  - If dirty[wr_sel+1] (mod slots): refuse the commit.
    - Pulse commit_fail for 1 cycle.
    - drop_cnt += 1, saturating at all-ones.
    - Write slot unchanged; its data may be overwritten by the producer.
  - Otherwise:
    - Set dirty[wr_sel].
    - Store flags[wr_sel]=wr_flags and len[wr_sel]=wr_len.
    - wr_sel += 1 (wraps at 2**N_WIDTH).
    - count += 1.
- Capacity: at most 2**N_WIDTH-1 committed frames. One slot is always owned by the writer.
- wr_abort: no pointer or dirty change. It only lets the producer restart at address 0. If wr_abort and wr_commit are asserted together, abort wins and the commit is ignored (no fail, no drop).
- rd_done:
  - If dirty[rd_sel]: clear it, rd_sel += 1 (wraps), count -= 1.
  - If rd_sel is clean: no effect.
- Commit and rd_done in the same cycle: both take effect.
  - count is net unchanged.
  - The full check uses pre-edge dirty, so a commit into a ring that is being freed in the same cycle still fails when dirty[wr_sel+1] was set.
- flush: highest priority; overrides commit, rd_done and abort in that cycle.
  - Sets wr_sel=rd_sel=0, dirty=0, count=0, commit_fail=0.
  - drop_cnt is NOT cleared by flush; only reset clears it.
- Outputs:
  - unread = (dirty != 0), combinational from state.
  - full = (count == 2**N_WIDTH-1), combinational.
- Widths: count, wr_sel and rd_sel wrap modulo 2**N_WIDTH. count can never wrap, because of the capacity rule.
- Reset mid-frame: all state cleared asynchronously. RAM contents are undefined and not cleared.

Test Plan:
1. Write words 0x11..0x14 at addr 0..3, commit with flags=0xA5, len=4 → unread=1, count=1. Then rd_en at addr 2 → next cycle rd_data=0x13, rd_flags=0xA5, rd_len=4.
2. N_WIDTH=2: three commits succeed (count=3, full=1). A fourth commit → commit_fail pulses 1 cycle, drop_cnt=1, count stays 3.
3. Ring full, commit and rd_done on the same edge → commit_fail=1, count=2, rd_sel advances to 1.
4. count=1, commit and rd_done on the same edge → count stays 1, wr_sel and rd_sel both advance.
5. C_WIDTH=2: five refused commits → drop_cnt counts 1,2,3,3,3. Then flush → count=0, unread=0, drop_cnt stays 3.
6. Assert reset_n low while wr_en is active mid-frame → all outputs 0 immediately, without waiting for a clk edge. After release, the next commit lands in slot 0.
